reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//   Consumer side of the clock-generation block. Takes the generated clock and its lock status.
//   Releases a set of downstream subsystem resets one stage at a time, in a fixed order.
//   Each stage must acknowledge readiness before the next stage is released.
//   Detects stages that never come up (timeout) and re-enters reset when lock is lost.
//   Sits directly after the clock block in the top level. Gates the reset of every datapath domain.
// PARAMETERS
//   NUM_STAGES   4     number of sequenced reset outputs, index 0 released first (>=1)
//   HOLD_CYCLES  16    cycles all resets stay asserted after lock is seen (>=1)
//   ACK_TIMEOUT  1024  cycles a released stage has to raise its ack (>=2)
//   SYNC_STAGES  2     synchronizer depth for locked_in (>=2)
// PORTS
//   clk_in           in   1                  single clock; all logic on posedge
//   rst_in           in   1                  reset, asynchronous, active-high
//   locked_in        in   1                  lock status from the clock block; asynchronous to clk_in
//   sw_reset_in      in   1                  synchronous 1-cycle request to restart the sequence
//   stage_ack_in     in   NUM_STAGES         per-stage "up and ready", level
//   stage_rst_out    out  NUM_STAGES         per-stage reset, active-high, registered
//   all_ready_out    out  1                  1 only while every stage is released and acked
//   fault_out        out  1                  sticky ack-timeout flag
//   fault_stage_out  out  $clog2(NUM_STAGES) index of the stage that timed out (width min 1)
// BEHAVIOUR
//   Reset
//   - rst_in=1 asynchronously sets all outputs, with no clock edge needed:
//     stage_rst_out='1, all_ready_out=0, fault_out=0, fault_stage_out=0, state=WAIT_LOCK, counters=0.
//   Lock synchronizer
//   - locked_in passes through SYNC_STAGES flops; the result is locked_s.
//   - Only locked_s is used by the FSM.
//   FSM states (all outputs registered)
//   - WAIT_LOCK: all resets asserted.
//     locked_s=1 -> HOLD, cnt=0.
//   - HOLD: all resets asserted, cnt increments each cycle.
//     At cnt==HOLD_CYCLES-1 -> WAIT_ACK, idx=0, stage_rst_out[0]<=0, cnt=0.
//   - WAIT_ACK: only stage_ack_in[idx] is examined; acks from other indices are ignored.
//     Sampling of ack starts on the first cycle in WAIT_ACK.
//     - ack=1 and idx<NUM_STAGES-1: stage_rst_out[idx+1]<=0, idx++, cnt=0. The next stage is released on that same edge.
//     - ack=1 and idx==NUM_STAGES-1 -> RUNNING, all_ready_out<=1.
//     - ack=0 and cnt==ACK_TIMEOUT-1 -> FAULT: fault_out<=1, fault_stage_out<=idx, stage_rst_out<='1.
//     - Otherwise cnt++.
//   - RUNNING: stage_rst_out='0, all_ready_out=1.
//     Later ack deassertion is not monitored.
//   - FAULT: all resets asserted, fault_out held.
//     Leaves only through rst_in or sw_reset_in.
//   Priority per edge, highest first
//   - 1. locked_s==0 in HOLD, WAIT_ACK or RUNNING -> WAIT_LOCK, stage_rst_out<='1, all_ready_out<=0.
//        fault_out is unchanged.
//   - 2. sw_reset_in=1 in any state except WAIT_LOCK -> HOLD, cnt=0, stage_rst_out<='1, all_ready_out<=0, fault_out<=0.
//        In WAIT_LOCK, sw_reset_in is ignored.
//   - 3. Normal FSM transition.
//   - The FAULT state ignores lock loss; the fault stays visible until it is cleared.
//   Arithmetic
//   - cnt width: $clog2(max(HOLD_CYCLES, ACK_TIMEOUT))+1. It never wraps because it is compared before increment.
//   Latency
//   - locked_in rise -> stage_rst_out[0] fall = SYNC_STAGES+1+HOLD_CYCLES edges.
//   - stage_ack_in[idx] sampled high -> next release on the same edge; all_ready_out on the same edge for the last stage.
//   Invariant
//   - Resets are only ever released in index order.
//   - stage_rst_out[k]=0 implies stage_rst_out[j]=0 for all j<k.
// STRUCTURE
//   - Package reset_seq_pkg holds:
//     - typedef enum logic[2:0] reset_seq_state_t {WAIT_LOCK, HOLD, WAIT_ACK, RUNNING, FAULT}.
//     - A config struct with the four parameters, matching the config-struct style used for clock configuration.
//   - Sub-module bit_synchronizer #(STAGES): generic N-flop synchronizer with async active-high reset to 0.
//     Used for locked_in and reusable elsewhere.
//   - The FSM, counters and output registers live in one always_ff plus one always_comb next-state block.
// TESTING
//   All tests use NUM_STAGES=3, HOLD_CYCLES=4, ACK_TIMEOUT=8, SYNC_STAGES=2.
//   1. Normal bring-up: locked_in rises at edge 0; each ack raised the cycle after its release
//      -> stage_rst_out goes 111 -> 110 at edge 7 -> 100 -> 000; all_ready_out=1 the edge ack[2] is sampled.
//   2. Timeout: ack[1] never raised -> fault_out=1 and fault_stage_out=1 exactly 8 edges after stage 1 release;
//      stage_rst_out=111; state stays FAULT for 100 cycles.
//   3. Lock loss in RUNNING: locked_in falls -> within 3 edges stage_rst_out=111 and all_ready_out=0;
//      relock -> sequence repeats as in test 1.
//   4. Async reset mid-WAIT_ACK: pulse rst_in between clock edges -> stage_rst_out=111 and all_ready_out=0
//      with no clock edge; after release the sequence restarts from WAIT_LOCK.
//   5. sw_reset_in in FAULT with lock held -> fault_out=0 next edge;
//      stage 0 released 4 edges later; sequence completes.
//   6. Stray acks: ack[2] held high from time 0, ack[0] pulsed during HOLD
//      -> no early release; order is strictly 0,1,2.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and configuration for the reset sequencer
package reset_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      HOLD,
      WAIT_ACK,
      RUNNING,
      FAULT
   } reset_seq_state_t;

   typedef struct packed {
      int unsigned num_stages;
      int unsigned hold_cycles;
      int unsigned ack_timeout;
      int unsigned sync_stages;
   } reset_seq_cfg_t;

   localparam reset_seq_cfg_t RESET_SEQ_CFG_DEFAULT = '{
      num_stages:  32'd4,
      hold_cycles: 32'd16,
      ack_timeout: 32'd1024,
      sync_stages: 32'd2
   };

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - generic N-flop single-bit synchronizer, async reset to 0
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases downstream resets in index order once clock lock is stable
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = int'(RESET_SEQ_CFG_DEFAULT.num_stages),
   parameter int HOLD_CYCLES = int'(RESET_SEQ_CFG_DEFAULT.hold_cycles),
   parameter int ACK_TIMEOUT = int'(RESET_SEQ_CFG_DEFAULT.ack_timeout),
   parameter int SYNC_STAGES = int'(RESET_SEQ_CFG_DEFAULT.sync_stages),
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  locked_in,
   input  logic                  sw_reset_in,
   input  logic [NUM_STAGES-1:0] stage_ack_in,
   output logic [NUM_STAGES-1:0] stage_rst_out,
   output logic                  all_ready_out,
   output logic                  fault_out,
   output logic [IW-1:0]         fault_stage_out
);

   localparam int CW = $clog2(max_u(HOLD_CYCLES, ACK_TIMEOUT)) + 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

   reset_seq_state_t      state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
   logic                  ready_q, ready_d;
   logic                  fault_q, fault_d;
   logic [IW-1:0]         fault_stage_q, fault_stage_d;
   logic                  locked_s;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk_in),
      .rst (rst_in),
      .d   (locked_in),
      .q   (locked_s)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q       <= WAIT_LOCK;
         cnt_q         <= '0;
         idx_q         <= '0;
         stage_rst_q   <= '1;
         ready_q       <= 1'b0;
         fault_q       <= 1'b0;
         fault_stage_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         stage_rst_q   <= stage_rst_d;
         ready_q       <= ready_d;
         fault_q       <= fault_d;
         fault_stage_q <= fault_stage_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      stage_rst_d   = stage_rst_q;
      ready_d       = ready_q;
      fault_d       = fault_q;
      fault_stage_d = fault_stage_q;

      // FAULT deliberately ignores lock loss so the flag stays visible until cleared
      if (!locked_s && (state_q == HOLD || state_q == WAIT_ACK || state_q == RUNNING)) begin
         state_d     = WAIT_LOCK;
         cnt_d       = '0;
         stage_rst_d = '1;
         ready_d     = 1'b0;
      end else if (sw_reset_in && state_q != WAIT_LOCK) begin
         state_d     = HOLD;
         cnt_d       = '0;
         stage_rst_d = '1;
         ready_d     = 1'b0;
         fault_d     = 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               stage_rst_d = '1;
               if (locked_s) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_d        = WAIT_ACK;
                  idx_d          = '0;
                  cnt_d          = '0;
                  stage_rst_d[0] = 1'b0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            WAIT_ACK: begin
               if (stage_ack_in[idx_q]) begin
                  if (idx_q != IDX_LAST) begin
                     // next stage comes out of reset on the same edge its predecessor is acked
                     for (int k = 0; k < NUM_STAGES; k++) begin
                        if (k == int'(idx_q) + 1) stage_rst_d[k] = 1'b0;
                     end
                     idx_d = idx_q + IW'(1);
                     cnt_d = '0;
                  end else begin
                     state_d = RUNNING;
                     ready_d = 1'b1;
                  end
               end else if (cnt_q == ACK_LAST) begin
                  state_d       = FAULT;
                  fault_d       = 1'b1;
                  fault_stage_d = idx_q;
                  stage_rst_d   = '1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RUNNING: begin
               stage_rst_d = '0;
               ready_d     = 1'b1;
            end
            FAULT: begin
               stage_rst_d = '1;
            end
            default: begin
               state_d     = WAIT_LOCK;
               stage_rst_d = '1;
               ready_d     = 1'b0;
            end
         endcase
      end
   end

   assign stage_rst_out   = stage_rst_q;
   assign all_ready_out   = ready_q;
   assign fault_out       = fault_q;
   assign fault_stage_out = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 4;
   localparam int ACKT = 8;
   localparam int SYNC = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         locked_in = 1'b0;
   logic         sw = 1'b0;
   logic [N-1:0] ack = '0;
   logic [N-1:0] stage_rst;
   logic         all_ready;
   logic         fault;
   logic [1:0]   fault_stage;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES (N),
      .HOLD_CYCLES(HOLD),
      .ACK_TIMEOUT(ACKT),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk_in         (clk),
      .rst_in         (rst),
      .locked_in      (locked_in),
      .sw_reset_in    (sw),
      .stage_ack_in   (ack),
      .stage_rst_out  (stage_rst),
      .all_ready_out  (all_ready),
      .fault_out      (fault),
      .fault_stage_out(fault_stage)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // model: lock pipeline, armed (lock seen), hold count, number of stages acked, fault flag
   bit [SYNC-1:0] m_pipe;
   bit            m_armed, m_seq, m_in_fault, m_fault;
   int            m_hold, m_acked, m_wait, m_fstage;

   function automatic logic [N-1:0] exp_rst();
      logic [N-1:0] v;
      int rel;
      v = '1;
      if (m_seq && !m_in_fault) begin
         rel = (m_acked >= N) ? N : m_acked + 1;
         for (int k = 0; k < rel; k++) v[k] = 1'b0;
      end
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pipe = '0; m_armed = 0; m_seq = 0; m_in_fault = 0; m_fault = 0;
         m_hold = 0; m_acked = 0; m_wait = 0; m_fstage = 0;
      end else begin : mdl
         bit ls;
         ls = m_pipe[SYNC-1];
         if (m_in_fault) begin
            if (sw) begin m_in_fault = 0; m_fault = 0; m_armed = 1; m_hold = 0; end
         end else if (m_armed && !ls) begin
            m_armed = 0; m_seq = 0; m_acked = 0;
         end else if (m_armed && sw) begin
            m_fault = 0; m_seq = 0; m_acked = 0; m_hold = 0;
         end else if (!m_armed) begin
            if (ls) begin m_armed = 1; m_hold = 0; end
         end else if (!m_seq) begin
            if (m_hold == HOLD - 1) begin m_seq = 1; m_acked = 0; m_wait = 0; end
            else m_hold++;
         end else if (m_acked < N) begin
            if (ack[m_acked]) begin m_acked++; m_wait = 0; end
            else if (m_wait == ACKT - 1) begin
               m_in_fault = 1; m_fault = 1; m_fstage = m_acked; m_seq = 0;
            end else m_wait++;
         end
         m_pipe = {m_pipe[SYNC-2:0], locked_in};
      end
   end

   always @(negedge clk) begin
      if (!rst) begin : cmp
         logic [N-1:0] rel;
         rel = ~stage_rst;
         chk("cyc_stage_rst", stage_rst, exp_rst());
         chk("cyc_ready", all_ready, (m_seq && m_acked == N));
         chk("cyc_fault", fault, m_fault);
         chk("cyc_fault_stage", fault_stage, m_fstage);
         chk("cyc_order", ((rel & (rel + 1'b1)) == '0), 1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bring_up(input string tag);
      tick(6); chk({tag, "_held"}, stage_rst, 3'b111);
      tick(1); chk({tag, "_rel0"}, stage_rst, 3'b110);
   endtask

   task automatic ack_walk(input string tag);
      ack = 3'b001; tick(1); chk({tag, "_rel1"}, stage_rst, 3'b100);
      ack = 3'b011; tick(1); chk({tag, "_rel2"}, stage_rst, 3'b000);
      chk({tag, "_notready"}, all_ready, 0);
      ack = 3'b111; tick(1); chk({tag, "_ready"}, all_ready, 1);
      chk({tag, "_allrel"}, stage_rst, 3'b000);
   endtask

   task automatic async_pulse(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk({tag, "_async_rst"}, stage_rst, 3'b111);
      chk({tag, "_async_ready"}, all_ready, 0);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #1 chk("rst_stage_rst", stage_rst, 3'b111);
      chk("rst_ready", all_ready, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_stage", fault_stage, 0);
      tick(2);
      rst = 1'b0;
      tick(3); chk("idle_no_lock", stage_rst, 3'b111);

      // normal bring-up
      locked_in = 1'b1;
      bring_up("t1");
      ack_walk("t1");

      // lock loss in RUNNING, then relock
      locked_in = 1'b0;
      tick(3); chk("t3_lost_rst", stage_rst, 3'b111);
      chk("t3_lost_ready", all_ready, 0);
      ack = '0; locked_in = 1'b1;
      bring_up("t3");
      ack_walk("t3");

      // async reset from RUNNING, then again mid WAIT_ACK
      ack = '0;
      async_pulse("t4a");
      bring_up("t4a");
      tick(2); chk("t4_mid_wait", stage_rst, 3'b110);
      async_pulse("t4b");
      bring_up("t4b");

      // stage 1 never acks
      ack = 3'b001;
      tick(1); chk("t2_rel1", stage_rst, 3'b100);
      tick(7); chk("t2_no_fault_yet", fault, 0);
      tick(1); chk("t2_fault", fault, 1);
      chk("t2_fault_stage", fault_stage, 1);
      chk("t2_fault_rst", stage_rst, 3'b111);
      locked_in = 1'b0;
      tick(50); chk("t2_fault_lockloss", fault, 1);
      locked_in = 1'b1;
      tick(50); chk("t2_fault_held", fault, 1);
      chk("t2_fault_rst_held", stage_rst, 3'b111);

      // software restart out of FAULT
      sw = 1'b1; ack = '0;
      tick(1); sw = 1'b0;
      chk("t5_fault_clr", fault, 0);
      chk("t5_rst", stage_rst, 3'b111);
      tick(3); chk("t5_held", stage_rst, 3'b111);
      tick(1); chk("t5_rel0", stage_rst, 3'b110);
      ack_walk("t5");

      // stray acks: ack[2] high throughout, ack[0] pulse in HOLD
      locked_in = 1'b0;
      tick(3);
      locked_in = 1'b1; ack = 3'b100;
      tick(3);
      ack = 3'b101; tick(1);
      ack = 3'b100; tick(2); chk("t6_held", stage_rst, 3'b111);
      tick(1); chk("t6_rel0", stage_rst, 3'b110);
      tick(3); chk("t6_no_early", stage_rst, 3'b110);
      ack = 3'b101; tick(1); chk("t6_rel1", stage_rst, 3'b100);
      ack = 3'b111; tick(1); chk("t6_rel2", stage_rst, 3'b000);
      chk("t6_notready", all_ready, 0);
      tick(1); chk("t6_ready", all_ready, 1);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
